// File: rtl/sort_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sort_pkg
// Description : Shared constants for the merge-sort feed path: default tree
//               geometry, block width and scheduler state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package sort_pkg;

    localparam int c_num_ways  = 8;
    localparam int c_blk_elems = 16;
    localparam int c_blk_bits  = 512;

    localparam logic [2:0] c_st_idle    = 3'd0;
    localparam logic [2:0] c_st_load    = 3'd1;
    localparam logic [2:0] c_st_wait_sn = 3'd2;
    localparam logic [2:0] c_st_arb     = 3'd3;
    localparam logic [2:0] c_st_drain   = 3'd4;

    // Pointer width that stays legal for a single-way tree.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Round-robin grant: first requesting way at or above ptr,
//               wrapping modulo NUM_WAYS. Purely combinational.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import sort_pkg::*;
#(
    parameter int NUM_WAYS = c_num_ways,
    parameter int PTR_W    = ptr_width(NUM_WAYS)
) (
    input  logic [NUM_WAYS-1:0] req,
    input  logic [PTR_W-1:0]    ptr,
    output logic [NUM_WAYS-1:0] grant,
    output logic                any
);

    logic [2*NUM_WAYS-1:0] w_req_dbl;
    logic [NUM_WAYS-1:0]   w_rot;
    logic [NUM_WAYS-1:0]   w_sel;
    logic [2*NUM_WAYS-1:0] w_gnt_dbl;

    // Rotate so bit 0 is the way at ptr, pick the lowest bit, rotate back.
    assign w_req_dbl = {req, req};
    assign w_rot     = NUM_WAYS'(w_req_dbl >> ptr);

    always_comb begin
        w_sel = '0;
        any   = 1'b0;
        for (int i = 0; i < NUM_WAYS; i++) begin
            if (!any && w_rot[i]) begin
                w_sel[i] = 1'b1;
                any      = 1'b1;
            end
        end
    end

    assign w_gnt_dbl = {{NUM_WAYS{1'b0}}, w_sel} << ptr;
    assign grant     = w_gnt_dbl[NUM_WAYS-1:0] | w_gnt_dbl[2*NUM_WAYS-1:NUM_WAYS];

endmodule
`default_nettype wire

// File: rtl/merge_feed_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : merge_feed_scheduler
// Description : Feeds sorted blocks into a merge tree and drains its output.
//               Define FEED_TIMEOUT_EN to abort a job when no way requests.
// Revision    : 1.0 - initial release
// ============================================================================
module merge_feed_scheduler
    import sort_pkg::*;
#(
    parameter int NUM_WAYS  = c_num_ways,
    parameter int BLK_ELEMS = c_blk_elems,
    parameter int TIMEOUT   = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  src_valid,
    output logic                  src_ready,
    input  logic [c_blk_bits-1:0] src_data,
    output logic [c_blk_bits-1:0] sn_din,
    output logic                  sn_ena,
    input  logic                  sn_valid,
    input  logic [NUM_WAYS-1:0]   im_req,
    output logic [NUM_WAYS-1:0]   im_ena,
    input  logic                  t_empty,
    input  logic                  out_ready,
    output logic                  t_deq,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int c_pw    = ptr_width(NUM_WAYS);
    localparam int c_total = NUM_WAYS * BLK_ELEMS;
    localparam int c_oc_w  = $clog2(c_total + 1);
    localparam int c_bc_w  = $clog2(NUM_WAYS + 1);

    logic [2:0]          r_state;
    logic [2:0]          w_state_nxt;
    logic [c_pw-1:0]     r_ptr;
    logic [c_pw-1:0]     w_ptr_nxt;
    logic [c_bc_w-1:0]   r_blk_cnt;
    logic [c_oc_w-1:0]   r_out_cnt;
    logic [NUM_WAYS-1:0] w_grant;
    logic                w_any;
    logic                w_timeout;

    rr_arbiter #(
        .NUM_WAYS (NUM_WAYS),
        .PTR_W    (c_pw)
    ) u_rr_arbiter (
        .req   (im_req),
        .ptr   (r_ptr),
        .grant (w_grant),
        .any   (w_any)
    );

    always_comb begin
        w_ptr_nxt = '0;
        for (int i = 0; i < NUM_WAYS; i++) begin
            if (w_grant[i]) begin
                w_ptr_nxt = (i == NUM_WAYS - 1) ? '0 : c_pw'(i + 1);
            end
        end
    end

`ifdef FEED_TIMEOUT_EN
    localparam int c_to_w = $clog2(TIMEOUT + 1);

    logic [c_to_w-1:0] r_to_cnt;

    // Counts consecutive grant-less ARB cycles; any other cycle restarts it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_to_cnt <= '0;
        end else if (r_state == c_st_arb && !w_any && !w_timeout) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end else begin
            r_to_cnt <= '0;
        end
    end

    assign w_timeout = (r_state == c_st_arb) && !w_any &&
                       (r_to_cnt == c_to_w'(TIMEOUT - 1));
`else
    // Constant 0 for any legal TIMEOUT: ARB waits forever.
    assign w_timeout = (TIMEOUT < 0);
`endif

    always_comb begin
        w_state_nxt = r_state;
        src_ready   = 1'b0;
        sn_ena      = 1'b0;
        im_ena      = '0;
        t_deq       = 1'b0;
        done        = 1'b0;
        err         = 1'b0;
        busy        = (r_state != c_st_idle);
        case (r_state)
            c_st_idle: begin
                if (start) w_state_nxt = c_st_load;
            end
            c_st_load: begin
                src_ready = 1'b1;
                if (src_valid) w_state_nxt = c_st_wait_sn;
            end
            c_st_wait_sn: begin
                sn_ena = 1'b1;
                if (sn_valid) w_state_nxt = c_st_arb;
            end
            c_st_arb: begin
                sn_ena = 1'b1;
                im_ena = w_grant;
                if (w_any) begin
                    w_state_nxt = (r_blk_cnt == c_bc_w'(NUM_WAYS - 1)) ? c_st_drain : c_st_load;
                end else if (w_timeout) begin
                    err         = 1'b1;
                    w_state_nxt = c_st_idle;
                end
            end
            c_st_drain: begin
                t_deq = !t_empty && out_ready;
                if (t_deq && r_out_cnt == c_oc_w'(c_total - 1)) begin
                    done        = 1'b1;
                    w_state_nxt = c_st_idle;
                end
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= c_st_idle;
            sn_din    <= '0;
            r_ptr     <= '0;
            r_blk_cnt <= '0;
            r_out_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (src_ready && src_valid) sn_din <= src_data;
            if (r_state == c_st_arb && w_any) begin
                r_ptr     <= w_ptr_nxt;
                r_blk_cnt <= r_blk_cnt + 1'b1;
            end
            if (t_deq) r_out_cnt <= r_out_cnt + 1'b1;
            // Job end (normal or aborted) leaves a clean slate for the next start.
            if (done || err) begin
                r_ptr     <= '0;
                r_blk_cnt <= '0;
                r_out_cnt <= '0;
            end
        end
    end

endmodule
`default_nettype wire
